decode_ctrl_stage: RTL and testbench

Registered instruction-decode/control stage for the pipelined RV32I core, sitting between the ID and EX stages. It decodes a 32-bit instruction into the EX-stage control bundle and registers it into the ID/EX boundary with a valid/ready handshake. It also owns load-use hazard detection, flush, and a multi-cycle hold for M-extension ops. Relative to the earlier combinational control decoder, it adds JALR, LUI and AUIPC, illegal-opcode flagging, stall/flush, and a configurable register-index width.

---
 rtl/decode_pkg.sv | 59 +++++
 rtl/decode_ctrl_stage_alu_decode.sv | 41 ++++
 rtl/decode_ctrl_stage.sv | 226 ++++++++++++++++++++++
 tb/tb_decode_ctrl_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions for the ID/EX boundary.
// Holds the RV32I opcode constants, the ALU-control and result-source
// encodings, the FSM state type and the packed control bundle that is
// registered into EX.
package decode_pkg;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLL  = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } result_src_e;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MDU_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic        regwrite;
    logic        memwrite;
    logic        jump;
    logic        jalr;
    logic        branch;
    logic        alu_src;
    logic        alu_a_pc;
    result_src_e result_src;
    logic [3:0]  alu_control;
    logic [2:0]  branch_control;
    logic        illegal;
    logic        mdu;
  } ctrl_t;

endpackage

// File: rtl/decode_ctrl_stage_alu_decode.sv
// alu_decode: combinational opcode/funct3/funct7 -> alu_control.
// Ports:
//   i_opcode, i_funct3, i_funct7b5 : instruction fields
//   i_mop                          : instruction is an M-extension op
//   o_alu_control                  : 4-bit ALU operation
module alu_decode
  import decode_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_mop,
  output logic [3:0] o_alu_control
);

  always_comb begin
    o_alu_control = ALU_ADD;
    if (i_mop) begin
      o_alu_control = {1'b0, i_funct3};
    end else begin
      case (i_opcode)
        OP_B: o_alu_control = ALU_SUB;
        OP_R, OP_I: begin
          case (i_funct3)
            // bit 30 is part of the immediate for ADDI, so only R-type subtracts
            3'b000:  o_alu_control = (i_opcode == OP_R && i_funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  o_alu_control = ALU_SLL;
            3'b010:  o_alu_control = ALU_SLT;
            3'b011:  o_alu_control = ALU_SLTU;
            3'b100:  o_alu_control = ALU_XOR;
            3'b101:  o_alu_control = i_funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  o_alu_control = ALU_OR;
            default: o_alu_control = ALU_AND;
          endcase
        end
        default: o_alu_control = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: registered ID->EX decode/control stage with valid/ready
// handshake, load-use hazard stall, flush and multi-cycle M-op hold.
// Optional feature macro: DECODE_MEXT_EN (M-extension decode + MDU hold FSM).
// Ports:
//   clk, rst (sync, active-high)
//   instr_d/valid_d/ready_d : ID-side instruction handshake
//   ready_e, flush_e        : EX acceptance and kill
//   valid_e + *_e           : registered EX control bundle, rd_e, illegal_e, mdu_e
module decode_ctrl_stage
  import decode_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MDU_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr_d,
  input  logic                  valid_d,
  output logic                  ready_d,
  input  logic                  ready_e,
  input  logic                  flush_e,
  output logic                  valid_e,
  output logic                  regwrite_e,
  output logic                  memwrite_e,
  output logic                  jump_e,
  output logic                  jalr_e,
  output logic                  branch_e,
  output logic                  alu_src_e,
  output logic                  alu_a_pc_e,
  output logic [1:0]            result_src_e,
  output logic [3:0]            alu_control_e,
  output logic [2:0]            branch_control_e,
  output logic [REG_ADDR_W-1:0] rd_e,
  output logic                  illegal_e,
  output logic                  mdu_e
);

  logic [6:0]            w_opcode;
  logic [2:0]            w_funct3;
  logic [6:0]            w_funct7;
  logic [REG_ADDR_W-1:0] w_rd, w_rs1, w_rs2;
  logic                  w_mop;
  logic [3:0]            w_alu_op;
  ctrl_t                 w_ctrl;
  logic                  w_uses_rs2;
  logic                  w_load_use;
  logic                  w_mdu_busy;
  logic                  w_load;

  logic                  r_valid;
  ctrl_t                 r_ctrl;
  logic [REG_ADDR_W-1:0] r_rd;

  assign w_opcode = instr_d[6:0];
  assign w_funct3 = instr_d[14:12];
  assign w_funct7 = instr_d[31:25];
  assign w_rd     = instr_d[7  +: REG_ADDR_W];
  assign w_rs1    = instr_d[15 +: REG_ADDR_W];
  assign w_rs2    = instr_d[20 +: REG_ADDR_W];

`ifdef DECODE_MEXT_EN
  assign w_mop = (w_opcode == OP_R) && (w_funct7 == FUNCT7_MEXT);
`else
  assign w_mop = 1'b0;
`endif

  alu_decode u_alu_decode (
    .i_opcode      (w_opcode),
    .i_funct3      (w_funct3),
    .i_funct7b5    (w_funct7[5]),
    .i_mop         (w_mop),
    .o_alu_control (w_alu_op)
  );

  always_comb begin
    w_ctrl = '0;
    case (w_opcode)
      OP_LW: begin
        w_ctrl.regwrite   = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.result_src = RES_MEM;
      end
      OP_SW: begin
        w_ctrl.alu_src  = 1'b1;
        w_ctrl.memwrite = 1'b1;
      end
      OP_R: begin
        if (w_funct7 == FUNCT7_MEXT) begin
`ifdef DECODE_MEXT_EN
          w_ctrl.regwrite = 1'b1;
          w_ctrl.mdu      = 1'b1;
`else
          w_ctrl.illegal  = 1'b1;
`endif
        end else begin
          w_ctrl.regwrite = 1'b1;
        end
      end
      OP_I: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.alu_src  = 1'b1;
      end
      OP_B: begin
        w_ctrl.branch         = 1'b1;
        w_ctrl.branch_control = w_funct3;
      end
      OP_JAL: begin
        w_ctrl.regwrite   = 1'b1;
        w_ctrl.jump       = 1'b1;
        w_ctrl.result_src = RES_PC4;
      end
      OP_JALR: begin
        w_ctrl.regwrite   = 1'b1;
        w_ctrl.jump       = 1'b1;
        w_ctrl.jalr       = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.result_src = RES_PC4;
      end
      OP_LUI: begin
        w_ctrl.regwrite   = 1'b1;
        w_ctrl.result_src = RES_IMM;
      end
      OP_AUIPC: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.alu_src  = 1'b1;
        w_ctrl.alu_a_pc = 1'b1;
      end
      default: w_ctrl.illegal = 1'b1;
    endcase
    // undecodable instructions carry a clean bundle apart from the flag
    w_ctrl.alu_control = w_ctrl.illegal ? 4'(ALU_ADD) : w_alu_op;
  end

  // rs2 is only a real source for R, S and B formats
  assign w_uses_rs2 = (w_opcode == OP_R) || (w_opcode == OP_SW) || (w_opcode == OP_B);

  assign w_load_use = r_valid && (r_ctrl.result_src == RES_MEM) && (r_rd != '0) &&
                      ((r_rd == w_rs1) || (w_uses_rs2 && (r_rd == w_rs2)));

  assign ready_d = ready_e && !flush_e && !w_load_use && !w_mdu_busy;
  assign w_load  = valid_d && ready_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_rd    <= '0;
    end else if (flush_e) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_rd    <= '0;
    end else if (!ready_e || w_mdu_busy) begin
      r_valid <= r_valid;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_ctrl  <= w_ctrl;
      r_rd    <= w_rd;
    end else begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_rd    <= '0;
    end
  end

`ifdef DECODE_MEXT_EN
  localparam int CNT_W = (MDU_LATENCY > 1) ? $clog2(MDU_LATENCY) : 1;

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The first EX cycle of an M-op is the load cycle itself, so the hold
  // covers MDU_LATENCY-1 further cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_load && w_ctrl.mdu && (MDU_LATENCY > 1)) begin
          w_state_nxt = ST_MDU_BUSY;
          w_cnt_nxt   = CNT_W'(MDU_LATENCY - 1);
        end
      end
      default: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_RUN;
        end
      end
    endcase
    if (flush_e) begin
      w_state_nxt = ST_RUN;
      w_cnt_nxt   = '0;
    end
  end

  assign w_mdu_busy = (r_state == ST_MDU_BUSY);
`else
  assign w_mdu_busy = 1'b0;
`endif

  assign valid_e          = r_valid;
  assign regwrite_e       = r_ctrl.regwrite;
  assign memwrite_e       = r_ctrl.memwrite;
  assign jump_e           = r_ctrl.jump;
  assign jalr_e           = r_ctrl.jalr;
  assign branch_e         = r_ctrl.branch;
  assign alu_src_e        = r_ctrl.alu_src;
  assign alu_a_pc_e       = r_ctrl.alu_a_pc;
  assign result_src_e     = r_ctrl.result_src;
  assign alu_control_e    = r_ctrl.alu_control;
  assign branch_control_e = r_ctrl.branch_control;
  assign rd_e             = r_rd;
  assign illegal_e        = r_ctrl.illegal;
  assign mdu_e            = r_ctrl.mdu;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed testbench for decode_ctrl_stage. Covers both builds
// (DECODE_MEXT_EN defined or not) for the M-op vectors.
module tb_decode_ctrl_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_d;
  logic        valid_d;
  logic        ready_d;
  logic        ready_e;
  logic        flush_e;
  logic        valid_e;
  logic        regwrite_e, memwrite_e, jump_e, jalr_e, branch_e, alu_src_e, alu_a_pc_e;
  logic [1:0]  result_src_e;
  logic [3:0]  alu_control_e;
  logic [2:0]  branch_control_e;
  logic [4:0]  rd_e;
  logic        illegal_e;
  logic        mdu_e;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // {illegal, mdu, rw, mw, jump, jalr, branch, alu_src, alu_a_pc, res[2], alu[4], bc[3]}
  logic [17:0] w_obs;
  assign w_obs = {illegal_e, mdu_e, regwrite_e, memwrite_e, jump_e, jalr_e, branch_e,
                  alu_src_e, alu_a_pc_e, result_src_e, alu_control_e, branch_control_e};

  localparam logic [31:0] I_LW_X5   = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] I_ADD_X5  = 32'h00128333; // add  x6,x5,x1
  localparam logic [31:0] I_LW_X0   = 32'h0000A003; // lw   x0,0(x1)
  localparam logic [31:0] I_ADD_X0  = 32'h00100333; // add  x6,x0,x1
  localparam logic [31:0] I_JALR    = 32'h000100E7; // jalr x1,0(x2)
  localparam logic [31:0] I_LUI     = 32'h12345237; // lui  x4,0x12345
  localparam logic [31:0] I_ILL     = 32'h0000007F; // opcode 1111111
  localparam logic [31:0] I_SUB     = 32'h402083B3; // sub  x7,x1,x2
  localparam logic [31:0] I_BNE     = 32'h00209063; // bne  x1,x2,0
  localparam logic [31:0] I_SRAI    = 32'h4034D413; // srai x8,x9,3
  localparam logic [31:0] I_MUL     = 32'h025201B3; // mul  x3,x4,x5

  localparam logic [17:0] B_NONE = 18'b0_0_0_0_0_0_0_0_0_00_0000_000;
  localparam logic [17:0] B_LW   = 18'b0_0_1_0_0_0_0_1_0_01_0000_000;
  localparam logic [17:0] B_ADD  = 18'b0_0_1_0_0_0_0_0_0_00_0000_000;
  localparam logic [17:0] B_JALR = 18'b0_0_1_0_1_1_0_1_0_10_0000_000;
  localparam logic [17:0] B_LUI  = 18'b0_0_1_0_0_0_0_0_0_11_0000_000;
  localparam logic [17:0] B_ILL  = 18'b1_0_0_0_0_0_0_0_0_00_0000_000;
  localparam logic [17:0] B_SUB  = 18'b0_0_1_0_0_0_0_0_0_00_0001_000;
  localparam logic [17:0] B_BNE  = 18'b0_0_0_0_0_0_1_0_0_00_0001_001;
  localparam logic [17:0] B_SRAI = 18'b0_0_1_0_0_0_0_1_0_00_1000_000;
  localparam logic [17:0] B_MUL  = 18'b0_1_1_0_0_0_0_0_0_00_0000_000;

  decode_ctrl_stage #(.REG_ADDR_W(5), .MDU_LATENCY(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .instr_d          (instr_d),
    .valid_d          (valid_d),
    .ready_d          (ready_d),
    .ready_e          (ready_e),
    .flush_e          (flush_e),
    .valid_e          (valid_e),
    .regwrite_e       (regwrite_e),
    .memwrite_e       (memwrite_e),
    .jump_e           (jump_e),
    .jalr_e           (jalr_e),
    .branch_e         (branch_e),
    .alu_src_e        (alu_src_e),
    .alu_a_pc_e       (alu_a_pc_e),
    .result_src_e     (result_src_e),
    .alu_control_e    (alu_control_e),
    .branch_control_e (branch_control_e),
    .rd_e             (rd_e),
    .illegal_e        (illegal_e),
    .mdu_e            (mdu_e)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] ins, input logic v);
    instr_d = ins;
    valid_d = v;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ready_e = 1'b1; flush_e = 1'b0;
    put(I_LW_X5, 1'b1);
    tick(); tick();
    check_eq("rst_valid", valid_e, 0);
    check_eq("rst_bundle", w_obs, B_NONE);
    check_eq("rst_rd", rd_e, 0);
    check_eq("rst_ready", ready_d, 1);
    ready_e = 1'b0; #1;
    check_eq("rst_ready_follows", ready_d, 0);
    ready_e = 1'b1;
    rst = 1'b0;

    // load-use: LW x5 then ADD x6,x5,x1
    put(I_LW_X5, 1'b1);
    tick();
    check_eq("lw_valid", valid_e, 1);
    check_eq("lw_bundle", w_obs, B_LW);
    check_eq("lw_rd", rd_e, 5);
    put(I_ADD_X5, 1'b1);
    check_eq("hazard_ready", ready_d, 0);
    tick();
    check_eq("bubble_valid", valid_e, 0);
    check_eq("bubble_bundle", w_obs, B_NONE);
    check_eq("after_bubble_ready", ready_d, 1);
    tick();
    check_eq("add_valid", valid_e, 1);
    check_eq("add_bundle", w_obs, B_ADD);
    check_eq("add_rd", rd_e, 6);

    // LW x0 never stalls
    put(I_LW_X0, 1'b1);
    tick();
    put(I_ADD_X0, 1'b1);
    check_eq("x0_ready", ready_d, 1);
    tick();
    check_eq("x0_add_valid", valid_e, 1);
    check_eq("x0_add_bundle", w_obs, B_ADD);

    // reset mid-stream with valid_e=1
    rst = 1'b1;
    put(I_JALR, 1'b1);
    tick();
    check_eq("midrst_valid", valid_e, 0);
    check_eq("midrst_bundle", w_obs, B_NONE);
    rst = 1'b0;

    // JALR, then flush with LUI offered: flush wins, LUI not consumed
    put(I_JALR, 1'b1);
    tick();
    check_eq("jalr_bundle", w_obs, B_JALR);
    check_eq("jalr_rd", rd_e, 1);
    flush_e = 1'b1;
    put(I_LUI, 1'b1);
    check_eq("flush_ready", ready_d, 0);
    tick();
    check_eq("flush_valid", valid_e, 0);
    check_eq("flush_bundle", w_obs, B_NONE);
    flush_e = 1'b0;
    tick();
    check_eq("lui_valid", valid_e, 1);
    check_eq("lui_bundle", w_obs, B_LUI);
    check_eq("lui_rd", rd_e, 4);

    put(I_ILL, 1'b1);
    tick();
    check_eq("ill_valid", valid_e, 1);
    check_eq("ill_bundle", w_obs, B_ILL);
    put(I_SUB, 1'b1);
    tick();
    check_eq("sub_bundle", w_obs, B_SUB);
    check_eq("sub_rd", rd_e, 7);
    put(I_BNE, 1'b1);
    tick();
    check_eq("bne_bundle", w_obs, B_BNE);
    put(I_SRAI, 1'b1);
    tick();
    check_eq("srai_bundle", w_obs, B_SRAI);

    // EX back-pressure holds the bundle
    ready_e = 1'b0;
    put(I_SUB, 1'b1);
    check_eq("bp_ready", ready_d, 0);
    tick();
    check_eq("bp_valid", valid_e, 1);
    check_eq("bp_bundle", w_obs, B_SRAI);
    ready_e = 1'b1;

    // hazard and flush together: flush wins, no stall after
    put(I_LW_X5, 1'b1);
    tick();
    flush_e = 1'b1;
    put(I_ADD_X5, 1'b1);
    tick();
    check_eq("hzfl_valid", valid_e, 0);
    flush_e = 1'b0; #1;
    check_eq("hzfl_ready", ready_d, 1);
    tick();
    check_eq("hzfl_add_bundle", w_obs, B_ADD);

`ifdef DECODE_MEXT_EN
    put(I_MUL, 1'b1);
    tick();
    check_eq("mul_bundle", w_obs, B_MUL);
    check_eq("mul_rd", rd_e, 3);
    put(I_ADD_X0, 1'b1);
    for (int unsigned i = 0; i < 3; i++) begin
      check_eq("mul_hold_ready", ready_d, 0);
      check_eq("mul_hold_bundle", w_obs, B_MUL);
      check_eq("mul_hold_valid", valid_e, 1);
      tick();
    end
    check_eq("mul_last_bundle", w_obs, B_MUL);
    check_eq("mul_release_ready", ready_d, 1);
    tick();
    check_eq("mul_next_add", w_obs, B_ADD);
    // abort the hold with a flush in cycle 2
    put(I_MUL, 1'b1);
    tick();
    put(I_ADD_X0, 1'b1);
    tick();
    flush_e = 1'b1;
    tick();
    check_eq("mul_flush_valid", valid_e, 0);
    check_eq("mul_flush_bundle", w_obs, B_NONE);
    flush_e = 1'b0; #1;
    check_eq("mul_flush_ready", ready_d, 1);
`else
    put(I_MUL, 1'b1);
    tick();
    check_eq("mul_ill_bundle", w_obs, B_ILL);
    put(I_ADD_X0, 1'b1);
    check_eq("mul_ill_ready", ready_d, 1);
    tick();
    check_eq("mul_ill_next_add", w_obs, B_ADD);
`endif

    // idle input gives a bubble with every bit cleared
    put(32'h0, 1'b0);
    tick();
    check_eq("idle_valid", valid_e, 0);
    check_eq("idle_bundle", w_obs, B_NONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
